// File: rtl/sudoku_pkg.sv
// -----------------------------------------------------------------------------
// sudoku_pkg
// Shared constants, check-FSM state encoding and the group-to-cell mapping
// used by the 4x4 Sudoku checker datapath.
//
// Group numbering:
//   0..3   rows 0..3
//   4..7   columns 0..3
//   8..11  2x2 boxes; box b covers rows 2*(b>>1)..+1, cols 2*(b&1)..+1
// -----------------------------------------------------------------------------
package sudoku_pkg;

  localparam int N       = 4;   // board edge length
  localparam int NGROUPS = 12;  // 4 rows + 4 columns + 4 boxes

  localparam logic [3:0] GRP_ROW0  = 4'd0;
  localparam logic [3:0] GRP_COL0  = 4'd4;
  localparam logic [3:0] GRP_BOX0  = 4'd8;
  localparam logic [3:0] GRP_LAST  = 4'(NGROUPS - 1);
  localparam logic [3:0] FAIL_NONE = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    DONE = 2'b10
  } state_t;

  // Map (group, slot) to the flat cell index r*4+c.
  // Rows take slot as the column, columns take slot as the row, and boxes
  // split slot into a row bit (slot[1]) and a column bit (slot[0]).
  function automatic logic [3:0] cell_idx(input logic [3:0] grp,
                                          input logic [1:0] slot);
    logic [1:0] off;
    logic [3:0] idx;
    if (grp < GRP_COL0) begin
      off = 2'(grp - GRP_ROW0);
      idx = {off, slot};
    end else if (grp < GRP_BOX0) begin
      off = 2'(grp - GRP_COL0);
      idx = {slot, off};
    end else begin
      off = 2'(grp - GRP_BOX0);
      idx = {off[1], slot[1], off[0], slot[0]};
    end
    return idx;
  endfunction

endpackage

// File: rtl/sudoku_group_check.sv
// -----------------------------------------------------------------------------
// sudoku_group_check
// Purely combinational legality test for one Sudoku group of four cells.
// A group is legal iff every cell holds a digit 1..4 and the four digits
// together cover {1,2,3,4} exactly once each.
//
// Ports:
//   cell0..cell3  in   CELL_W  cell values (0 = empty, 5..7 = illegal)
//   legal         out  1       group is a permutation of 1..4
// -----------------------------------------------------------------------------
module sudoku_group_check #(
  parameter int CELL_W = 3
) (
  input  logic [CELL_W-1:0] cell0,
  input  logic [CELL_W-1:0] cell1,
  input  logic [CELL_W-1:0] cell2,
  input  logic [CELL_W-1:0] cell3,
  output logic              legal
);

  logic [CELL_W-1:0] cells [4];
  logic [3:0]        hot   [4];
  logic [3:0]        seen;
  logic              all_digits;

  assign cells[0] = cell0;
  assign cells[1] = cell1;
  assign cells[2] = cell2;
  assign cells[3] = cell3;

  // One-hot decode per cell; empty and out-of-range values decode to zero,
  // so they both fail the range test and leave a hole in the coverage mask.
  always_comb begin
    // NOTE: every variable gets a default before the case/loop so no path
    // leaves it unassigned, which would otherwise infer a latch.
    seen       = 4'b0000;
    all_digits = 1'b1;
    for (int i = 0; i < 4; i++) begin
      case (cells[i])
        CELL_W'(1): hot[i] = 4'b0001;
        CELL_W'(2): hot[i] = 4'b0010;
        CELL_W'(3): hot[i] = 4'b0100;
        CELL_W'(4): hot[i] = 4'b1000;
        default:    hot[i] = 4'b0000;
      endcase
      seen       = seen | hot[i];
      all_digits = all_digits & (|hot[i]);
    end
    legal = all_digits && (seen == 4'b1111);
  end

endmodule

// File: rtl/sudoku_checker.sv
// -----------------------------------------------------------------------------
// sudoku_checker
// Datapath responder to the game FSM's check request. On an accepted request
// the board is captured, then the 12 groups (rows, columns, boxes) are
// scanned one per clock through a single group checker. A one-cycle done
// strobe reports a held solved verdict and the first failing group index.
//
// Parameters:
//   CELL_W      bits per cell (0 empty, 1..4 digit, others illegal)
//   EARLY_EXIT  1: stop at the first failing group; 0: always scan all 12
//
// Ports:
//   clka      in   1          clock, rising edge
//   restart   in   1          asynchronous active-high reset
//   dp_check  in   1          check request, sampled only in IDLE
//   board     in   16*CELL_W  cell (r,c) at [(r*4+c)*CELL_W +: CELL_W]
//   busy      out  1          high in SCAN and DONE
//   done      out  1          one-cycle result strobe
//   solved    out  1          verdict, held until the next accepted request
//   fail_grp  out  4          first failing group, 4'hF when none
// -----------------------------------------------------------------------------
module sudoku_checker
  import sudoku_pkg::*;
#(
  parameter int CELL_W     = 3,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                  clka,
  input  logic                  restart,
  input  logic                  dp_check,
  input  logic [16*CELL_W-1:0]  board,
  output logic                  busy,
  output logic                  done,
  output logic                  solved,
  output logic [3:0]            fail_grp
);

  state_t                state, state_next;
  logic [3:0]            grp_idx, grp_idx_next;
  logic [16*CELL_W-1:0]  board_q, board_next;
  logic                  solved_next;
  logic [3:0]            fail_next;

  logic [CELL_W-1:0]     cell_q [16];
  logic [CELL_W-1:0]     sel    [N];
  logic                  grp_legal;

  // Unpack the captured board into addressable cells.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      cell_q[i] = board_q[i*CELL_W +: CELL_W];
    end
  end

  // 4-way operand mux: pick the four cells of the current group.
  always_comb begin
    for (int s = 0; s < N; s++) begin
      sel[s] = cell_q[cell_idx(grp_idx, 2'(s))];
    end
  end

  sudoku_group_check #(
    .CELL_W (CELL_W)
  ) u_group_check (
    .cell0 (sel[0]),
    .cell1 (sel[1]),
    .cell2 (sel[2]),
    .cell3 (sel[3]),
    .legal (grp_legal)
  );

  // Next-state and output decode.
  always_comb begin
    state_next   = state;
    grp_idx_next = grp_idx;
    board_next   = board_q;
    solved_next  = solved;
    fail_next    = fail_grp;
    busy         = (state != IDLE);
    done         = (state == DONE);

    case (state)
      IDLE: begin
        if (dp_check) begin
          board_next   = board;
          grp_idx_next = GRP_ROW0;
          solved_next  = 1'b0;
          fail_next    = FAIL_NONE;
          state_next   = SCAN;
        end
      end

      SCAN: begin
        // Only the first failure is recorded; later ones (full-scan mode)
        // leave the reported index untouched.
        if (!grp_legal && (fail_grp == FAIL_NONE)) begin
          fail_next = grp_idx;
        end

        if (EARLY_EXIT && !grp_legal) begin
          state_next = DONE;
        end else if (grp_idx == GRP_LAST) begin
          state_next  = DONE;
          solved_next = (fail_grp == FAIL_NONE) && grp_legal;
        end else begin
          grp_idx_next = grp_idx + 4'd1;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // NOTE: the captured board is an ordinary register bank, so it is cleared
  // on reset along with the control state; nothing is left undefined after
  // restart.
  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      state    <= IDLE;
      grp_idx  <= '0;
      board_q  <= '0;
      solved   <= 1'b0;
      fail_grp <= FAIL_NONE;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed by the combinational block.
      state    <= state_next;
      grp_idx  <= grp_idx_next;
      board_q  <= board_next;
      solved   <= solved_next;
      fail_grp <= fail_next;
    end
  end

endmodule

// File: tb/tb_sudoku_checker.sv
// -----------------------------------------------------------------------------
// tb_sudoku_checker
// Drives two checkers in parallel from the same stimulus: one with early exit,
// one always scanning all 12 groups. Hand-derived vectors, randomized boards
// against a behavioural model, and multi-cycle corner sequences (restart
// mid-scan, requests while busy, request held high, board changed after
// capture).
// -----------------------------------------------------------------------------
module tb_sudoku_checker;

  localparam int CW = 3;
  localparam int BW = 16 * CW;

  logic          clk;
  logic          restart;
  logic          dp_check;
  logic [BW-1:0] board;

  logic       busy_a, done_a, solved_a;
  logic [3:0] fail_a;
  logic       busy_b, done_b, solved_b;
  logic [3:0] fail_b;

  int tests = 0;
  int fails = 0;

  sudoku_checker #(.CELL_W(CW), .EARLY_EXIT(1'b1)) dut_a (
    .clka     (clk),
    .restart  (restart),
    .dp_check (dp_check),
    .board    (board),
    .busy     (busy_a),
    .done     (done_a),
    .solved   (solved_a),
    .fail_grp (fail_a)
  );

  sudoku_checker #(.CELL_W(CW), .EARLY_EXIT(1'b0)) dut_b (
    .clka     (clk),
    .restart  (restart),
    .dp_check (dp_check),
    .board    (board),
    .busy     (busy_b),
    .done     (done_b),
    .solved   (solved_b),
    .fail_grp (fail_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Board from four decimal row strings, e.g. 1234 -> cells 1,2,3,4.
  function automatic logic [BW-1:0] mk_board(input int r0, input int r1,
                                             input int r2, input int r3);
    logic [BW-1:0] b;
    int rows [4];
    int div  [4];
    rows = '{r0, r1, r2, r3};
    div  = '{1000, 100, 10, 1};
    b = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        b[(r*4+c)*CW +: CW] = CW'((rows[r] / div[c]) % 10);
    return b;
  endfunction

  function automatic int get_cell(input logic [BW-1:0] b, input int r,
                                  input int c);
    return int'(b[(r*4+c)*CW +: CW]);
  endfunction

  // Reference: walk groups in order, a group is legal iff its four values
  // are distinct members of 1..4. Latency is counted in edges after the
  // request edge until done is visible.
  task automatic model(input logic [BW-1:0] b, input bit early,
                       output bit s, output logic [3:0] f, output int lat);
    int  v [4];
    bit  seen [5];
    bit  ok;
    int  r, c, bx;
    f = 4'hF;
    for (int g = 0; g < 12; g++) begin
      for (int k = 0; k < 4; k++) begin
        if (g < 4) begin
          r = g; c = k;
        end else if (g < 8) begin
          r = k; c = g - 4;
        end else begin
          bx = g - 8;
          r = 2 * (bx / 2) + k / 2;
          c = 2 * (bx % 2) + k % 2;
        end
        v[k] = get_cell(b, r, c);
      end
      for (int d = 0; d < 5; d++) seen[d] = 1'b0;
      ok = 1'b1;
      for (int k = 0; k < 4; k++) begin
        if (v[k] < 1 || v[k] > 4) ok = 1'b0;
        else if (seen[v[k]]) ok = 1'b0;
        else seen[v[k]] = 1'b1;
      end
      if (!ok && f == 4'hF) f = 4'(g);
    end
    s   = (f == 4'hF);
    lat = (early && f != 4'hF) ? int'(f) + 1 : 12;
  endtask

  // Results of the last run_check.
  int         r_lat_a, r_lat_b, r_busy, r_dones_a, r_dones_b;
  bit         r_s_a, r_s_b, r_early;
  logic [3:0] r_f_a, r_f_b;

  // Issue one request, scramble the board after the capture edge, then watch
  // both checkers for a fixed 16-cycle window.
  task automatic run_check(input logic [BW-1:0] b, input bit pulse);
    r_lat_a = -1; r_lat_b = -1; r_busy = 0; r_dones_a = 0; r_dones_b = 0;
    r_early = 1'b0; r_s_a = 1'b0; r_s_b = 1'b0; r_f_a = 4'h0; r_f_b = 4'h0;
    @(negedge clk);
    board    = b;
    dp_check = 1'b1;
    @(negedge clk);
    dp_check = 1'b0;
    board    = {16'($urandom), $urandom};
    if (busy_a) r_busy++;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      if (pulse) dp_check = (n == 3 || n == 12);
      if (busy_a) r_busy++;
      if (done_a) begin
        r_dones_a++;
        if (r_lat_a < 0) begin r_lat_a = n; r_s_a = solved_a; r_f_a = fail_a; end
      end else if (r_lat_a < 0 && solved_a) r_early = 1'b1;
      if (done_b) begin
        r_dones_b++;
        if (r_lat_b < 0) begin r_lat_b = n; r_s_b = solved_b; r_f_b = fail_b; end
      end else if (r_lat_b < 0 && solved_b) r_early = 1'b1;
    end
    dp_check = 1'b0;
  endtask

  typedef struct {
    logic [BW-1:0] board;
    bit            exp_solved;
    logic [3:0]    exp_fail;
    int            exp_lat;   // early-exit latency; full scan is always 12
  } vec_t;

  task automatic check_run(input string tag, input bit es, input logic [3:0] ef,
                           input int el);
    check({tag, " solved_a"}, 32'(r_s_a), 32'(es));
    check({tag, " fail_a"},   32'(r_f_a), 32'(ef));
    check({tag, " lat_a"},    32'(r_lat_a), 32'(el));
    check({tag, " solved_b"}, 32'(r_s_b), 32'(es));
    check({tag, " fail_b"},   32'(r_f_b), 32'(ef));
    check({tag, " lat_b"},    32'(r_lat_b), 32'd12);
    check({tag, " busy_cycles_a"}, 32'(r_busy), 32'(el + 1));
    check({tag, " dones_a"},  32'(r_dones_a), 32'd1);
    check({tag, " dones_b"},  32'(r_dones_b), 32'd1);
    check({tag, " solved_before_done"}, 32'(r_early), 32'd0);
    check({tag, " held_solved_a"}, 32'(solved_a), 32'(es));
    check({tag, " held_fail_b"},   32'(fail_b), 32'(ef));
    check({tag, " idle_busy_b"},   32'(busy_b), 32'd0);
  endtask

  initial begin
    vec_t          vecs [6];
    logic [BW-1:0] valid, rb;
    bit            ms;
    logic [3:0]    mf;
    int            ml, ml_b;
    int            perm [4];
    int            tmp, j, d;
    int            t_a [2], t_b [2];
    int            na, nb;
    bit            s_a1;
    logic [3:0]    f_a2;

    valid = mk_board(1234, 3412, 2143, 4321);
    vecs[0] = '{valid,                               1'b1, 4'hF, 12};
    vecs[1] = '{mk_board(1234, 3412, 2141, 4321),    1'b0, 4'd2, 3};
    vecs[2] = '{mk_board(1234, 1234, 1234, 1234),    1'b0, 4'd4, 5};
    vecs[3] = '{mk_board(1234, 2341, 3412, 4123),    1'b0, 4'd8, 9};
    vecs[4] = '{mk_board(1234, 3412, 2143, 4320),    1'b0, 4'd3, 4};
    vecs[5] = '{mk_board(1234, 3412, 2143, 4325),    1'b0, 4'd3, 4};

    // Reset state.
    restart  = 1'b1;
    dp_check = 1'b0;
    board    = '0;
    #12;
    check("reset busy",   32'(busy_a),   32'd0);
    check("reset done",   32'(done_a),   32'd0);
    check("reset solved", 32'(solved_a), 32'd0);
    check("reset fail",   32'(fail_a),   32'hF);
    check("reset fail_b", 32'(fail_b),   32'hF);
    @(negedge clk);
    restart = 1'b0;
    @(negedge clk);
    check("idle busy", 32'(busy_a), 32'd0);

    // Hand-derived table.
    foreach (vecs[i]) begin
      run_check(vecs[i].board, 1'b0);
      check_run($sformatf("vec%0d", i), vecs[i].exp_solved, vecs[i].exp_fail,
                vecs[i].exp_lat);
    end

    // Randomized boards: relabelled valid boards with occasional corruption.
    for (int it = 0; it < 30; it++) begin
      perm = '{1, 2, 3, 4};
      for (int i = 3; i > 0; i--) begin
        j = $urandom_range(0, i);
        tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
      end
      for (int k = 0; k < 16; k++) begin
        d = int'(valid[k*CW +: CW]);
        rb[k*CW +: CW] = CW'(perm[d-1]);
      end
      if ($urandom_range(0, 2) != 0) begin
        for (int m = 0; m < int'($urandom_range(1, 2)); m++)
          rb[$urandom_range(0, 15)*CW +: CW] = CW'($urandom_range(0, 7));
      end
      model(rb, 1'b1, ms, mf, ml);
      model(rb, 1'b0, ms, mf, ml_b);
      run_check(rb, 1'b0);
      check_run($sformatf("rand%0d", it), ms, mf, ml);
    end

    // Requests while busy are ignored and never produce an extra done.
    run_check(valid, 1'b1);
    check_run("pulse_busy", 1'b1, 4'hF, 12);

    // Request held high: a new check starts one cycle after DONE and
    // re-captures the board, which is changed mid-scan of the first check.
    t_a = '{-1, -1}; t_b = '{-1, -1}; na = 0; nb = 0; s_a1 = 1'b0; f_a2 = 4'h0;
    @(negedge clk);
    board    = valid;
    dp_check = 1'b1;
    for (int n = 0; n <= 30; n++) begin
      @(negedge clk);
      if (n == 5) board = vecs[1].board;
      if (done_a && na < 2) begin
        t_a[na] = n;
        if (na == 0) s_a1 = solved_a; else f_a2 = fail_a;
        na++;
      end
      if (done_b && nb < 2) begin t_b[nb] = n; nb++; end
    end
    dp_check = 1'b0;
    check("held first_done_a",  32'(t_a[0]), 32'd12);
    check("held first_solved",  32'(s_a1),   32'd1);
    check("held second_done_a", 32'(t_a[1]), 32'd17);
    check("held second_fail_a", 32'(f_a2),   32'd2);
    check("held second_done_b", 32'(t_b[1]), 32'd26);
    repeat (16) @(negedge clk);
    check("held idle_a", 32'(busy_a), 32'd0);
    check("held idle_b", 32'(busy_b), 32'd0);

    // Restart mid-scan discards the in-progress result immediately.
    @(negedge clk);
    board    = vecs[1].board;
    dp_check = 1'b1;
    @(negedge clk);
    dp_check = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_restart busy_b", 32'(busy_b), 32'd1);
    check("pre_restart fail_b", 32'(fail_b), 32'd2);
    #2 restart = 1'b1;
    #1;
    check("restart busy_b",   32'(busy_b),   32'd0);
    check("restart done_b",   32'(done_b),   32'd0);
    check("restart solved_b", 32'(solved_b), 32'd0);
    check("restart fail_b",   32'(fail_b),   32'hF);
    check("restart fail_a",   32'(fail_a),   32'hF);
    @(negedge clk);
    restart = 1'b0;
    repeat (14) begin
      @(negedge clk);
      if (done_a || done_b || busy_a || busy_b) check("restart stray activity", 32'd1, 32'd0);
    end
    check("restart idle fail_b", 32'(fail_b), 32'hF);

    // A fresh check after restart still works.
    run_check(valid, 1'b0);
    check_run("post_restart", 1'b1, 4'hF, 12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
